// File: rtl/fbuf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fbuf_pkg
// Description : Shared defaults and types for the frame-buffer arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package fbuf_pkg;

   // Frame-buffer word address width and 4:4:4 RGB pixel width
   localparam int C_ADDR_W = 15;
   localparam int C_DATA_W = 12;

   // Source of the RAM read issued in the previous cycle
   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_VID  = 2'd1,
      OWN_DRW  = 2'd2
   } owner_e;

endpackage : fbuf_pkg
`default_nettype wire

// File: rtl/fbuf_wbuf.sv
`default_nettype none
// ============================================================================
// Module      : fbuf_wbuf
// Description : One-entry draw write buffer. Holds a draw write that could
//               not reach the RAM because scanout owned it; retires into the
//               RAM on the first cycle scanout is idle. Exists only when
//               FBUF_WRITE_BUFFER_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`ifdef FBUF_WRITE_BUFFER_EN
module fbuf_wbuf #(
   parameter int ADDR_W = 15,
   parameter int DATA_W = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [DATA_W-1:0] load_data,
   input  logic              retire,
   input  logic [ADDR_W-1:0] lookup_addr,
   output logic              valid,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] data,
   output logic              hit
);

   logic              r_valid;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_data;

   // Load only happens while empty and retire only while full, so they never collide
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_addr  <= '0;
         r_data  <= '0;
      end else if (load) begin
         r_valid <= 1'b1;
         r_addr  <= load_addr;
         r_data  <= load_data;
      end else if (retire) begin
         r_valid <= 1'b0;
      end
   end

   assign valid = r_valid;
   assign addr  = r_addr;
   assign data  = r_data;
   assign hit   = r_valid & (r_addr == lookup_addr);

endmodule : fbuf_wbuf
`endif
`default_nettype wire

// File: rtl/fbuf_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fbuf_arbiter
// Description : Single-port frame-buffer RAM arbiter. Scanout reads always
//               win and are issued in the same cycle; the draw engine gets
//               the leftover cycles. Read data returns one cycle after issue
//               and is routed by an owner register. Defining
//               FBUF_WRITE_BUFFER_EN adds a one-entry draw write buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module fbuf_arbiter
   import fbuf_pkg::*;
#(
   parameter int ADDR_W = C_ADDR_W,
   parameter int DATA_W = C_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              vid_req,
   input  logic [ADDR_W-1:0] vid_addr,
   output logic              vid_rvalid,
   output logic [DATA_W-1:0] vid_rdata,
   input  logic              drw_req,
   input  logic              drw_we,
   input  logic [ADDR_W-1:0] drw_addr,
   input  logic [DATA_W-1:0] drw_wdata,
   output logic              drw_gnt,
   output logic              drw_rvalid,
   output logic [DATA_W-1:0] drw_rdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic [15:0]       stall_cnt
);

   logic              w_vid_issue;
   logic              w_drw_gnt;
   logic              w_drw_rd;
   logic              w_ram_wr;
   logic [ADDR_W-1:0] w_wr_addr;
   logic [DATA_W-1:0] w_wr_data;
   logic [ADDR_W-1:0] w_ram_addr;
   logic [DATA_W-1:0] w_ram_wdata;
   logic              w_hit_pend;
   logic [DATA_W-1:0] w_hit_data;

   owner_e            r_owner;
   logic [ADDR_W-1:0] r_last_addr;
   logic [DATA_W-1:0] r_last_wdata;
   logic [15:0]       r_stall;

   // Reset blocks every issue so the RAM port stays quiet while rst is high
   assign w_vid_issue = ~rst & vid_req;

`ifdef FBUF_WRITE_BUFFER_EN
   logic              w_buf_valid;
   logic [ADDR_W-1:0] w_buf_addr;
   logic [DATA_W-1:0] w_buf_data;
   logic              w_buf_hit;
   logic              w_retire;
   logic              w_load;
   logic              w_hit_rd;
   logic              r_hit_pend;
   logic [DATA_W-1:0] r_hit_data;

   fbuf_wbuf #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_wbuf (
      .clk         (clk),
      .rst         (rst),
      .load        (w_load),
      .load_addr   (drw_addr),
      .load_data   (drw_wdata),
      .retire      (w_retire),
      .lookup_addr (drw_addr),
      .valid       (w_buf_valid),
      .addr        (w_buf_addr),
      .data        (w_buf_data),
      .hit         (w_buf_hit)
   );

   // Draw grant with buffer: writes need an empty buffer, buffered-address
   // reads are served from the buffer, other reads need a free RAM cycle
   always_comb begin
      w_retire  = ~rst & w_buf_valid & ~vid_req;
      w_drw_gnt = 1'b0;
      if (!rst && drw_req) begin
         if (drw_we)
            w_drw_gnt = ~w_buf_valid;
         else if (w_buf_hit)
            w_drw_gnt = 1'b1;
         else
            w_drw_gnt = ~vid_req & ~w_retire;
      end
      w_load   = w_drw_gnt & drw_we;
      w_hit_rd = w_drw_gnt & ~drw_we & w_buf_hit;
      w_drw_rd = w_drw_gnt & ~drw_we & ~w_buf_hit;
      w_ram_wr = w_retire;
      w_wr_addr = w_buf_addr;
      w_wr_data = w_buf_data;
   end

   // Buffer-hit reads return one cycle later, like RAM reads
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hit_pend <= 1'b0;
         r_hit_data <= '0;
      end else begin
         r_hit_pend <= w_hit_rd;
         r_hit_data <= w_buf_data;
      end
   end

   assign w_hit_pend = r_hit_pend;
   assign w_hit_data = r_hit_data;
`else
   // Draw grant without buffer: any draw access waits for a scanout-free cycle
   always_comb begin
      w_drw_gnt = ~rst & drw_req & ~vid_req;
      w_drw_rd  = w_drw_gnt & ~drw_we;
      w_ram_wr  = w_drw_gnt & drw_we;
      w_wr_addr = drw_addr;
      w_wr_data = drw_wdata;
   end

   assign w_hit_pend = 1'b0;
   assign w_hit_data = '0;
`endif

   // RAM port mux; with nothing issued the address and write data hold
   always_comb begin
      w_ram_addr  = r_last_addr;
      w_ram_wdata = r_last_wdata;
      if (w_vid_issue) begin
         w_ram_addr = vid_addr;
      end else if (w_ram_wr) begin
         w_ram_addr  = w_wr_addr;
         w_ram_wdata = w_wr_data;
      end else if (w_drw_rd) begin
         w_ram_addr = drw_addr;
      end
   end

   // Owner of the read in flight, held RAM port values and saturating stall count
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_owner      <= OWN_NONE;
         r_last_addr  <= '0;
         r_last_wdata <= '0;
         r_stall      <= '0;
      end else begin
         if (w_vid_issue)
            r_owner <= OWN_VID;
         else if (w_drw_rd)
            r_owner <= OWN_DRW;
         else
            r_owner <= OWN_NONE;
         r_last_addr  <= w_ram_addr;
         r_last_wdata <= w_ram_wdata;
         if (drw_req && !w_drw_gnt && (r_stall != 16'hFFFF))
            r_stall <= r_stall + 16'd1;
      end
   end

   assign drw_gnt    = w_drw_gnt;
   assign ram_addr   = w_ram_addr;
   assign ram_we     = w_ram_wr;
   assign ram_wdata  = w_ram_wdata;
   assign stall_cnt  = r_stall;

   assign vid_rvalid = (r_owner == OWN_VID);
   assign vid_rdata  = (r_owner == OWN_VID) ? ram_rdata : '0;
   assign drw_rvalid = (r_owner == OWN_DRW) | w_hit_pend;
   assign drw_rdata  = w_hit_pend              ? w_hit_data :
                       (r_owner == OWN_DRW)    ? ram_rdata  : '0;

endmodule : fbuf_arbiter
`default_nettype wire

// File: doc/fbuf_arbiter.md
FBUF_ARBITER -- requirements
Module: fbuf_arbiter

Interface
REQ-001 Parameter ADDR_W, default 15, frame-buffer word address width (matches pixel_addr).
REQ-002 Parameter DATA_W, default 12, pixel word width (4:4:4 RGB).
REQ-003 Clk  input  1  system clock (50 MHz); the only clock.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 vid_req  input  1  scanout read request, one per pixel fetch.
REQ-006 vid_addr  input  ADDR_W  scanout read address.
REQ-007 vid_rvalid  output  1  scanout read data valid.
REQ-008 vid_rdata  output  DATA_W  scanout read data.
REQ-009 drw_req  input  1  draw-engine request; held until granted.
REQ-010 drw_we  input  1  draw request is a write (1) or read (0).
REQ-011 drw_addr  input  ADDR_W  draw address.
REQ-012 drw_wdata  input  DATA_W  draw write data.
REQ-013 drw_gnt  output  1  draw request accepted this cycle.
REQ-014 drw_rvalid  output  1  draw read data valid.
REQ-015 drw_rdata  output  DATA_W  draw read data.
REQ-016 ram_addr  output  ADDR_W  single-port RAM address.
REQ-017 ram_we  output  1  RAM write enable.
REQ-018 ram_wdata  output  DATA_W  RAM write data.
REQ-019 ram_rdata  input  DATA_W  RAM read data, valid one cycle after a read issue.
REQ-020 stall_cnt  output  16  saturating count of cycles drw_req was denied.

Function
REQ-021 Exactly one RAM access SHALL be issued per cycle: video, draw, or none.
REQ-022 vid_req SHALL always win; the video read is issued combinationally in the same cycle, never delayed.
REQ-023 drw_gnt SHALL assert combinationally when drw_req=1 and vid_req=0 (and, with buffer, no pending flush per REQ-032).
REQ-024 An owner register SHALL record the issued read source (NONE/VID/DRW); one cycle later exactly the matching rvalid pulses with rdata = ram_rdata.
REQ-025 Read latency SHALL be exactly 1 cycle from issue to rvalid for both requesters; writes produce no rvalid.
REQ-026 Back-to-back reads from alternating requesters SHALL each return correctly routed data on consecutive cycles.
REQ-027 With nothing issued, ram_we=0 and ram_addr SHALL hold its previous value.
REQ-028 stall_cnt SHALL increment each cycle drw_req=1 and drw_gnt=0, saturating at 16'hFFFF.
REQ-029 Draw read-after-write to the same address SHALL return the written data.

Reset
REQ-030 On Reset: owner=NONE, vid_rvalid=0, drw_rvalid=0, vid_rdata=0, drw_rdata=0, drw_gnt=0, ram_we=0, ram_addr=0, ram_wdata=0, stall_cnt=0, write buffer empty; an in-flight read is discarded (no rvalid after release).

Configuration
REQ-031 Macro FBUF_WRITE_BUFFER_EN SHALL compile in a one-entry draw write buffer; without it draw writes follow REQ-023 and contend directly.
REQ-032 With buffer: a draw write SHALL be granted whenever the buffer is empty, even with vid_req=1; the buffer retires on the next cycle with vid_req=0, taking priority over a new draw request that cycle; a draw read to the buffered address SHALL return buffer data (1-cycle latency, no RAM issue); writes while full stall per REQ-023.

Structure
REQ-033 Package fbuf_pkg SHALL hold ADDR_W/DATA_W defaults and the owner enum (OWN_NONE, OWN_VID, OWN_DRW).
REQ-034 The optional write buffer SHALL be a sub-module fbuf_wbuf (valid, addr, data; load/retire/hit ports).

Verification
REQ-035 Reset asserted mid-read -> no rvalid after release, stall_cnt=0, ram_we=0.
REQ-036 vid_req=1 addr 15'h0010 and drw_req read 15'h0020 same cycle -> RAM addr 0x010, drw_gnt=0, vid_rvalid next cycle with RAM[0x10], stall_cnt=1; drw granted next idle cycle.
REQ-037 Draw write 0x1234 <- 12'hABC, then draw read 0x1234 -> drw_rvalid one cycle after read grant, drw_rdata=12'hABC.
REQ-038 Alternating vid/drw reads for 8 cycles -> each rvalid routed to correct requester with correct data, never both in one cycle.
REQ-039 drw_req held with vid_req=1 for 70000 cycles -> stall_cnt=16'hFFFF, no wrap.
REQ-040 FBUF_WRITE_BUFFER_EN: draw write during vid_req=1 -> drw_gnt=1 same cycle; ram_we=1 on first cycle vid_req=0; read of that address before retire returns buffered data.
